// File: rtl/mem_block_responder.sv
// Block-memory responder: one 128-bit line per request, mem_ready LATENCY cycles after the request is seen in IDLE.
// No queueing: a request is accepted only in IDLE, and the initiator holds it until the mem_ready pulse.
module mem_block_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic         proto_err,
  output logic [15:0]  rd_cnt,
  output logic [15:0]  wr_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  typedef struct packed {
    logic                  wr;
    logic [DEPTH_LOG2-1:0] idx;
    logic [127:0]          wdat;
  } req_t;

  localparam int         LP_LINES    = 1 << DEPTH_LOG2;
  localparam logic [3:0] LP_CNT_LOAD = 4'(LATENCY - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  req_t                  r_req;
  logic [3:0]            r_cnt;
  logic [127:0]          r_mem [LP_LINES];
  logic [127:0]          r_rdata;
  logic                  r_proto_err;
  logic [15:0]           r_rd_cnt;
  logic [15:0]           r_wr_cnt;

  logic                  w_req;
  logic                  w_accept;
  logic                  w_active_line;
  logic                  w_read_op;
  logic                  w_load_rdata;
  logic                  w_unused_addr;
  logic [DEPTH_LOG2-1:0] w_in_idx;
  logic [DEPTH_LOG2-1:0] w_rd_idx;

  assign w_req         = mem_read | mem_write;
  assign w_in_idx      = mem_addr[DEPTH_LOG2-1:0];
  assign w_unused_addr = ^mem_addr[27:DEPTH_LOG2];
  assign w_accept      = (r_state == ST_IDLE) && w_req;
  assign w_active_line = r_req.wr ? mem_write : mem_read;

  // A simultaneous read+write request is executed as a write.
  assign w_read_op    = (r_state == ST_IDLE) ? !mem_write : !r_req.wr;
  assign w_rd_idx     = (r_state == ST_IDLE) ? w_in_idx : r_req.idx;
  assign w_load_rdata = (w_state_nxt == ST_RESP) && (r_state != ST_RESP) && w_read_op;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_state_nxt = (LATENCY > 1) ? ST_BUSY : ST_RESP;
      ST_BUSY: if (r_cnt == 4'd1) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (r_state == ST_RESP);
  end

  // The latched request itself needs no reset: it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_cnt       <= 4'd0;
      r_rdata     <= '0;
      r_proto_err <= 1'b0;
      r_rd_cnt    <= 16'd0;
      r_wr_cnt    <= 16'd0;
    end else begin
      if (w_accept) begin
        r_req <= '{wr: mem_write, idx: w_in_idx, wdat: mem_wdata};
        r_cnt <= LP_CNT_LOAD;
        if (mem_read && mem_write) r_proto_err <= 1'b1;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt - 4'd1;
        if (!w_active_line) r_proto_err <= 1'b1;
      end
      if (w_load_rdata) r_rdata <= r_mem[w_rd_idx];
      if (r_state == ST_RESP) begin
        if (r_req.wr) begin
          if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
        end else begin
          if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
        end
      end
    end
  end

  // Array commits only on a completed write; reset aborts it and never clears contents.
  always_ff @(posedge clk) begin
    if (!proc_reset && (r_state == ST_RESP) && r_req.wr) begin
      r_mem[r_req.idx] <= r_req.wdat;
    end
  end

  assign mem_rdata = r_rdata;
  assign proto_err = r_proto_err;
  assign rd_cnt    = r_rd_cnt;
  assign wr_cnt    = r_wr_cnt;

endmodule

// File: tb/tb_mem_block_responder.sv
// Randomized + directed bench: expectations pushed at issue, popped by a monitor on every mem_ready.
module tb_mem_block_responder;

  localparam int LAT = 4;
  localparam int DL  = 8;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready, proto_err;
  logic [15:0]  rd_cnt, wr_cnt;

  logic         rd1, wr1;
  logic [27:0]  addr1;
  logic [127:0] wdata1, rdata1;
  logic         ready1, perr1;
  logic [15:0]  rc1, wc1;

  always #5 clk = ~clk;

  mem_block_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .proc_reset(proc_reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .proto_err(proto_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  mem_block_responder #(.LATENCY(1), .DEPTH_LOG2(DL)) dut1 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(rd1), .mem_write(wr1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ready(ready1),
    .proto_err(perr1), .rd_cnt(rc1), .wr_cnt(wc1)
  );

  typedef struct {
    int           cyc;
    logic [127:0] data;
  } exp_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [127:0] model_mem [256];
  logic [127:0] last_rd;
  int           m_rd, m_wr;
  int           next_idle;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor: each completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready @cycle %0d: got ready=1 with no outstanding request", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ready_cycle", 128'(cyc), 128'(mon_e.cyc));
        chk("rdata", mem_rdata, mon_e.data);
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents a request; the model decides completion cycle and data from the memory rules.
  task automatic start_op(input bit rd, input bit wr, input logic [27:0] a,
                          input logic [127:0] d, input bit track);
    exp_t e;
    int   acc;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    acc = (cyc > next_idle) ? cyc : next_idle;
    if (track) begin
      e.cyc = acc + LAT;
      if (wr) begin
        model_mem[a[DL-1:0]] = d;
        m_wr++;
        e.data = last_rd;
      end else begin
        e.data  = model_mem[a[DL-1:0]];
        last_rd = e.data;
        m_rd++;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) seen = 1'b1;
    end
    if (seen) begin
      next_idle = cyc + 1;
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout @cycle %0d: got no mem_ready within 40 cycles, required one", cyc);
    end
  endtask

  task automatic op(input bit rd, input bit wr, input logic [27:0] a,
                    input logic [127:0] d, input int gap);
    if (gap > 0) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      repeat (gap) @(negedge clk);
    end
    start_op(rd, wr, a, d, 1'b1);
    wait_ready();
  endtask

  task automatic go_idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    rd1        = 1'b0;
    wr1        = 1'b0;
    proc_reset = 1'b1;
    repeat (n) @(negedge clk);
    chk("rst_ready", 128'(mem_ready), 128'd0);
    chk("rst_proto_err", 128'(proto_err), 128'd0);
    chk("rst_rd_cnt", 128'(rd_cnt), 128'd0);
    chk("rst_wr_cnt", 128'(wr_cnt), 128'd0);
    chk("rst_rdata", mem_rdata, 128'd0);
    chk("rst_l1_ready", 128'(ready1), 128'd0);
    chk("rst_l1_cnts", 128'({rc1, wc1}), 128'd0);
    proc_reset = 1'b0;
    next_idle  = cyc;
    last_rd    = '0;
    m_rd       = 0;
    m_wr       = 0;
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k1;
    logic [127:0] kc;
    logic [127:0] d;
    logic [27:0]  a;
    bit           rd;
    proc_reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    last_rd = '0; m_rd = 0; m_wr = 0; next_idle = 0;
    @(negedge clk);
    do_reset(3);

    // LATENCY=1 instance: write, then a read held high completes every second cycle.
    k1 = rnd128();
    wr1 = 1'b1; addr1 = 28'h3; wdata1 = k1;
    @(negedge clk);
    chk("l1_write_ready", 128'(ready1), 128'd1);
    wr1 = 1'b0; rd1 = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      chk("l1_ready_pattern", 128'(ready1), 128'(j % 2 == 0));
      if (ready1 === 1'b1) chk("l1_rdata", rdata1, k1);
    end
    rd1 = 1'b0;
    chk("l1_rd_cnt_before", 128'(rc1), 128'd3);
    @(negedge clk);
    chk("l1_rd_cnt", 128'(rc1), 128'd4);
    chk("l1_wr_cnt", 128'(wc1), 128'd1);
    chk("l1_proto_err", 128'(perr1), 128'd0);

    // Write then read of line 5.
    kc = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    op(1'b0, 1'b1, 28'h5, kc, 1);
    op(1'b1, 1'b0, 28'h5, '0, 0);
    go_idle();
    chk("wr_cnt_first", 128'(wr_cnt), 128'(m_wr));
    chk("rd_cnt_first", 128'(rd_cnt), 128'(m_rd));

    for (int i = 0; i < 256; i++) op(1'b0, 1'b1, 28'(i), rnd128(), int'($urandom_range(0, 1)));

    // Back-to-back: read of 0x20 accepted in the first IDLE cycle after a write.
    op(1'b0, 1'b1, 28'h10, rnd128(), 0);
    op(1'b1, 1'b0, 28'h20, '0, 1);
    // Upper address bits ignored.
    op(1'b0, 1'b1, 28'h0000105, rnd128(), 0);
    op(1'b1, 1'b0, 28'h0000005, '0, 0);
    go_idle();
    chk("proto_err_clean", 128'(proto_err), 128'd0);

    op(1'b1, 1'b1, 28'h30, rnd128(), 0);
    go_idle();
    chk("proto_err_both", 128'(proto_err), 128'd1);
    op(1'b1, 1'b0, 28'h30, '0, 0);
    go_idle();

    // Request dropped during BUSY still completes, but flags an error.
    do_reset(2);
    start_op(1'b1, 1'b0, 28'h31, '0, 1'b1);
    @(negedge clk);
    mem_read = 1'b0;
    wait_ready();
    go_idle();
    chk("proto_err_drop", 128'(proto_err), 128'd1);
    chk("rd_cnt_drop", 128'(rd_cnt), 128'd1);

    // Reset in BUSY aborts a write to 0x7 without touching the array.
    do_reset(2);
    start_op(1'b0, 1'b1, 28'h7, rnd128(), 1'b0);
    repeat (2) @(negedge clk);
    do_reset(1);
    repeat (6) @(negedge clk);
    op(1'b1, 1'b0, 28'h7, '0, 0);
    go_idle();
    chk("rd_cnt_after_abort", 128'(rd_cnt), 128'd1);
    chk("wr_cnt_after_abort", 128'(wr_cnt), 128'd0);

    for (int i = 0; i < 200; i++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 28'($urandom);
      d  = rnd128();
      op(rd, !rd, a, d, int'($urandom_range(0, 2)));
    end
    go_idle();
    repeat (2) @(negedge clk);
    chk("rd_cnt_final", 128'(rd_cnt), 128'(m_rd));
    chk("wr_cnt_final", 128'(wr_cnt), 128'(m_wr));
    chk("pending_final", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
